vita49_pack_mc: RTL

VITA49_PACK_MC -- requirements
Module: vita49_pack_mc

---
 rtl/vita49_pack_mc_if.sv | 23 ++
 rtl/vita49_pack_mc.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vita49_pack_mc_if.sv
// Stream bundle for vita49_pack_mc: NUM_CHAN AXI-Stream input lanes and the packed output stream.
interface vita49_pack_mc_if #(
    parameter int NUM_CHAN = 2
);
    logic [32*NUM_CHAN-1:0] S_AXIS_TDATA;
    logic [NUM_CHAN-1:0]    S_AXIS_TVALID;
    logic [NUM_CHAN-1:0]    S_AXIS_TLAST;
    logic [NUM_CHAN-1:0]    S_AXIS_TREADY;
    logic [31:0]            M_AXIS_TDATA;
    logic                   M_AXIS_TVALID;
    logic                   M_AXIS_TLAST;
    logic                   M_AXIS_TREADY;

    modport master (
        input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
        output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
    );

    modport slave (
        output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
        input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST
    );
endinterface

// File: rtl/vita49_pack_mc.sv
// Multi-channel VITA49 packetiser: picks an input stream round-robin and wraps its samples in
// header, stream ID, optional class ID, timestamps, zero padding and an optional trailer.
module vita49_pack_mc #(
    parameter int NUM_CHAN = 2,
    parameter int CHW      = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1
) (
    input  logic             AXIS_ACLK,
    input  logic             AXIS_ARESET,
    vita49_pack_mc_if.master axis,
    input  logic [31:0]      ctrl,
    input  logic [31:0]      streamID_base,
    input  logic [63:0]      classID,
    input  logic [15:0]      pkt_size,
    input  logic [31:0]      trailer,
    input  logic [31:0]      timestamp_sec,
    input  logic [63:0]      timestamp_fsec,
    output logic [31:0]      status
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, HDR  = 4'd1, SID  = 4'd2, CID0 = 4'd3, CID1 = 4'd4, TSI = 4'd5,
        TSF0 = 4'd6, TSF1 = 4'd7, PAY  = 4'd8, ZERO = 4'd9, TRL  = 4'd10
    } state_t;

    state_t state_r, state_nxt;

    logic [31:0]     ctrl_r, sid_base_r, trailer_r;
    logic [63:0]     class_id_r;
    logic [15:0]     pkt_size_r;
    logic            c_r, t_r, size_err_r;
    logic [15:0]     len_r, word_cnt_r;
    logic [31:0]     sid_r, trl_r, ts_sec_r;
    logic [63:0]     cid_r, ts_fsec_r;
    logic [CHW-1:0]  sel_r, last_ch_r;
    logic [3:0]      pkt_cnt_r [NUM_CHAN];

    logic [NUM_CHAN-1:0] en_s, s_ready_s;
    logic                start_s, srst_s, too_small_s, pay_last_s;
    logic [15:0]         hdr_words_s, min_len_s;
    logic                sel_valid_s, sel_last_s, arb_found_s, launch_s, eop_s, m_fire_s;
    logic [31:0]         sel_data_s, m_data_s;
    logic                m_valid_s, m_last_s;
    logic [CHW-1:0]      arb_idx_s, cand_idx_s;
    int                  cand_s;
    logic                ctrl_unused_s;

    assign start_s       = ctrl_r[0];
    assign srst_s        = ctrl_r[1];
    assign en_s          = ctrl_r[4 +: NUM_CHAN];
    assign ctrl_unused_s = ^ctrl_r[31:4+NUM_CHAN];
    assign hdr_words_s   = 16'd5 + (ctrl_r[3] ? 16'd2 : 16'd0);
    assign min_len_s     = hdr_words_s + {15'd0, ctrl_r[2]} + 16'd1;
    assign too_small_s   = (pkt_size_r < min_len_s);
    assign pay_last_s    = (word_cnt_r == (len_r - {15'd0, t_r} - 16'd1));
    assign sel_valid_s   = axis.S_AXIS_TVALID[sel_r];
    assign sel_last_s    = axis.S_AXIS_TLAST[sel_r];
    assign sel_data_s    = axis.S_AXIS_TDATA[{sel_r, 5'd0} +: 32];
    assign m_fire_s      = m_valid_s & axis.M_AXIS_TREADY;

    // Round-robin search for a valid, enabled channel starting after the last one served
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = {CHW{1'b0}};
        cand_s      = 0;
        cand_idx_s  = {CHW{1'b0}};
        for (int i = 1; i <= NUM_CHAN; i++) begin
            cand_s = 32'(last_ch_r) + i;
            if (cand_s >= NUM_CHAN) cand_s = cand_s - NUM_CHAN;
            else                    cand_s = cand_s;
            cand_idx_s = CHW'(cand_s);
            if (!arb_found_s && en_s[cand_idx_s] && axis.S_AXIS_TVALID[cand_idx_s]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = cand_idx_s;
            end else begin
                arb_found_s = arb_found_s;
            end
        end
    end

    // Next-state logic; launch_s marks packet start, eop_s the final output transfer
    always_comb begin
        state_nxt = state_r;
        launch_s  = 1'b0;
        eop_s     = 1'b0;
        if (srst_s) begin
            state_nxt = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s && !too_small_s && arb_found_s) begin
                        state_nxt = HDR;
                        launch_s  = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                HDR:  state_nxt = m_fire_s ? SID : HDR;
                SID:  state_nxt = m_fire_s ? (c_r ? CID0 : TSI) : SID;
                CID0: state_nxt = m_fire_s ? CID1 : CID0;
                CID1: state_nxt = m_fire_s ? TSI : CID1;
                TSI:  state_nxt = m_fire_s ? TSF0 : TSI;
                TSF0: state_nxt = m_fire_s ? TSF1 : TSF0;
                TSF1: state_nxt = m_fire_s ? PAY : TSF1;
                PAY, ZERO: begin
                    // A TLAST landing on the last payload word ends normally, with no padding
                    if (m_fire_s && pay_last_s) begin
                        state_nxt = t_r ? TRL : IDLE;
                        eop_s     = ~t_r;
                    end else if (m_fire_s && sel_last_s && (state_r == PAY)) begin
                        state_nxt = ZERO;
                    end else begin
                        state_nxt = state_r;
                    end
                end
                TRL: begin
                    state_nxt = m_fire_s ? IDLE : TRL;
                    eop_s     = m_fire_s;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output word mux; everything except the payload pass-through comes from held registers
    always_comb begin
        m_data_s  = 32'd0;
        m_valid_s = 1'b0;
        m_last_s  = 1'b0;
        s_ready_s = {NUM_CHAN{1'b0}};
        case (state_r)
            HDR: begin
                m_valid_s = 1'b1;
                m_data_s  = {4'b0001, c_r, t_r, 2'b00, 2'b11, 2'b01, pkt_cnt_r[sel_r], len_r};
            end
            SID:  begin m_valid_s = 1'b1; m_data_s = sid_r;             end
            CID0: begin m_valid_s = 1'b1; m_data_s = cid_r[63:32];      end
            CID1: begin m_valid_s = 1'b1; m_data_s = cid_r[31:0];       end
            TSI:  begin m_valid_s = 1'b1; m_data_s = ts_sec_r;          end
            TSF0: begin m_valid_s = 1'b1; m_data_s = ts_fsec_r[63:32];  end
            TSF1: begin m_valid_s = 1'b1; m_data_s = ts_fsec_r[31:0];   end
            PAY: begin
                m_valid_s        = sel_valid_s;
                m_data_s         = sel_data_s;
                m_last_s         = sel_valid_s & pay_last_s & ~t_r;
                s_ready_s[sel_r] = axis.M_AXIS_TREADY;
            end
            ZERO: begin
                m_valid_s = 1'b1;
                m_last_s  = pay_last_s & ~t_r;
            end
            TRL: begin
                m_valid_s = 1'b1;
                m_data_s  = trl_r;
                m_last_s  = 1'b1;
            end
            default: m_valid_s = 1'b0;
        endcase
    end

    // Configuration inputs are sampled every cycle; only these copies feed the logic
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            ctrl_r     <= 32'd0;
            sid_base_r <= 32'd0;
            class_id_r <= 64'd0;
            pkt_size_r <= 16'd0;
            trailer_r  <= 32'd0;
        end else begin
            ctrl_r     <= ctrl;
            sid_base_r <= streamID_base;
            class_id_r <= classID;
            pkt_size_r <= pkt_size;
            trailer_r  <= trailer;
        end
    end

    // Packet state, counters and per-packet field snapshots
    always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
        if (AXIS_ARESET) begin
            state_r    <= IDLE;
            word_cnt_r <= 16'd0;
            size_err_r <= 1'b0;
            sel_r      <= {CHW{1'b0}};
            last_ch_r  <= CHW'(NUM_CHAN - 1);
            c_r        <= 1'b0;
            t_r        <= 1'b0;
            len_r      <= 16'd0;
            sid_r      <= 32'd0;
            cid_r      <= 64'd0;
            trl_r      <= 32'd0;
            ts_sec_r   <= 32'd0;
            ts_fsec_r  <= 64'd0;
            for (int k = 0; k < NUM_CHAN; k++) pkt_cnt_r[k] <= 4'd0;
        end else begin
            state_r <= state_nxt;
            if (srst_s || eop_s) word_cnt_r <= 16'd0;
            else if (m_fire_s)   word_cnt_r <= word_cnt_r + 16'd1;
            else                 word_cnt_r <= word_cnt_r;

            if (srst_s)                                size_err_r <= 1'b0;
            else if (state_r != IDLE)                  size_err_r <= size_err_r;
            else if (too_small_s && start_s)           size_err_r <= 1'b1;
            else if (!too_small_s)                     size_err_r <= 1'b0;
            else                                       size_err_r <= size_err_r;

            if (eop_s) begin
                pkt_cnt_r[sel_r] <= pkt_cnt_r[sel_r] + 4'd1;
                last_ch_r        <= sel_r;
            end
            if (launch_s) begin
                sel_r     <= arb_idx_s;
                c_r       <= ctrl_r[3];
                t_r       <= ctrl_r[2];
                len_r     <= pkt_size_r;
                sid_r     <= sid_base_r + {{(32-CHW){1'b0}}, arb_idx_s};
                cid_r     <= class_id_r;
                trl_r     <= trailer_r;
                ts_sec_r  <= timestamp_sec;
                ts_fsec_r <= timestamp_fsec;
            end
        end
    end

    assign axis.M_AXIS_TDATA  = m_data_s;
    assign axis.M_AXIS_TVALID = m_valid_s;
    assign axis.M_AXIS_TLAST  = m_last_s;
    assign axis.S_AXIS_TREADY = s_ready_s;
    assign status = {word_cnt_r, {(11-CHW){1'b0}}, sel_r, size_err_r, state_r};
endmodule
